sample_frame_fifo: RTL and testbench
====================================

# sample_frame_fifo

Buffers the four calibrated input channels (`cal_in0..3`) leaving the per-PMOD driver into a frame FIFO, one frame per `strobe`, for a downstream consumer that drains at its own pace. The consumer can be a DSP core, a USB audio bridge or a soft-CPU. Each frame is tagged with a free-running sequence number so the consumer can detect dropped frames. The block sits directly downstream of the PMOD driver, in the same `clk_256fs` domain.

## Interface
- `W`, 16, sample width in bits; matches the driver's sample width.
- `DEPTH`, 16, FIFO depth in frames; must be a power of 2, at least 2.
- `SEQ_W`, 16, sequence-number width in bits.

- `clk_256fs`  in  1  single clock. The block has exactly one clock domain.
- `rst`  in  1  synchronous reset, active-high.
- `strobe`  in  1  one-cycle pulse, once per sample period; the same strobe the driver uses.
- `cal_in0..cal_in3`  in  W signed each  calibrated input samples; stable when `strobe` is high.
- `frame_valid`  out  1  the head frame is presented on the outputs.
- `frame_ready`  in  1  the consumer accepts the head frame.
- `frame_ch0..frame_ch3`  out  W signed each  head-frame samples.
- `frame_seq`  out  SEQ_W  sequence number of the head frame.
- `level`  out  $clog2(DEPTH)+1  number of frames currently stored.
- `overflow`  out  1  sticky flag; set when any frame has been dropped.
- `drop_count`  out  16  saturating count of dropped frames.
- `clear_overflow`  in  1  clears `overflow` and `drop_count`.

## Operation
- **Sequence counter.** `seq_ctr` increments (wrapping) on every `strobe`, whether the frame is stored or dropped. A stored frame carries the `seq_ctr` value from before the increment.
- **Write.** A write is attempted on `strobe` with `{cal_in0..3, seq_ctr}`.
  - Accepted if `level < DEPTH`.
  - Also accepted if `level == DEPTH` and a pop occurs in the same cycle, because the freed slot is reused.
  - Otherwise the frame is dropped: the new frame is discarded and existing contents are kept.
- **Drop handling.**
  - `overflow` is set on every drop.
  - `drop_count` increments on every drop and saturates at 0xFFFF.
- **Pop.** A pop occurs when `frame_valid && frame_ready`. `frame_ready` while `frame_valid` is low has no effect.
- **Presentation.** The FIFO is show-ahead: `frame_ch*` and `frame_seq` always present the oldest stored frame. They are don't-care while `frame_valid` is low.
- **Handshake stability.** Once `frame_valid` is high, it and all frame outputs hold until a pop occurs.
- **Level.** `level` changes as follows:
  - +1 on an accepted write without a pop.
  - −1 on a pop without a write.
  - unchanged when both happen, or neither.
- **Pointers.** Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally. Full and empty are determined from `level`, not from pointer equality.
- **Clear versus drop.** `clear_overflow` has priority over a simultaneous drop: both counters go to 0, and that drop is not recorded.
- **Reset.**
  - All state is reset: pointers, `level`, `seq_ctr`, `overflow`, `drop_count`.
  - The frame memory is not reset.
  - A strobe coinciding with `rst` is ignored.
  - Reset asserted mid-operation discards all stored frames.

## Timing
- **Reset values.** `frame_valid`=0, `level`=0, `overflow`=0, `drop_count`=0, `frame_seq`=0, `frame_ch*`=0.
- **Write latency.** A strobe at cycle N into an empty FIFO gives `frame_valid`=1 at N+1, with data presented in the same cycle.
- **Pop latency.** A pop at cycle N presents the next frame at N+1. If no frame remains, `frame_valid`=0 at N+1.
- **Registered outputs.** All outputs are registered. There is no combinational path from `frame_ready` to any output.
- **Pass-through.** Write and pop on the same cycle when the FIFO is empty is impossible, because `frame_valid` is still 0; there is no fall-through.
- **Throughput.** At most one frame per cycle in each direction. Strobes are 256 cycles apart, so the consumer only needs to average at least one pop per 256 cycles.

## Structure
- Shared package `eurorack_pmod_pkg`:
  - `sample_t` (signed [W-1:0]).
  - `frame_t` packed struct `{sample_t ch[4]; logic [SEQ_W-1:0] seq;}`.
  - `N_CH` = 4.
- Sub-module `frame_ram`: simple dual-port array of `frame_t`, `DEPTH` entries, with a synchronous write port and a registered read port. It maps to BRAM or LUTRAM.
- Top-level module holds:
  - pointer and level control;
  - show-ahead output register (prefetch from `frame_ram` so the read latency is hidden);
  - sequence counter;
  - overflow logic.

## Test plan
- **Single frame.** Stimulus: reset, then one strobe with ch0..3 = 0x1234, −1, 0x7FFF, 0x8000 and `frame_ready`=0. Response: `frame_valid`=1 at N+1, those values on `frame_ch*`, `frame_seq`=0, `level`=1, held for 100 cycles.
- **Streaming.** Stimulus: 1000 strobes with `frame_ready` randomly toggled, average ≥1/256. Response: every frame received in order, `frame_seq` incrementing by 1, `overflow`=0.
- **Overflow.** Stimulus: `frame_ready`=0 for DEPTH+3 strobes. Response: `level`=16, `overflow`=1, `drop_count`=3. Draining yields seq 0..15, and the next accepted frame has seq 19.
- **Full with pop.** Stimulus: FIFO full, strobe and pop in the same cycle. Response: frame accepted, `level` stays 16, `drop_count` unchanged.
- **Clear during drop.** Stimulus: `clear_overflow` asserted in the same cycle as a drop. Response: `overflow`=0 and `drop_count`=0 next cycle.
- **Reset mid-operation.** Stimulus: `rst` asserted with `level`=5, together with a strobe in the same cycle. Response: `level`=0, `frame_valid`=0, `seq_ctr`=0; the next strobe yields seq 0.

Source files
------------

// File: rtl/eurorack_pmod_pkg.sv
// Shared types for the eurorack PMOD sample path: channel count, sample and frame layouts.
package eurorack_pmod_pkg;

  localparam int unsigned N_CH      = 4;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned SEQ_W_DEF = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t [N_CH-1:0]     ch;
    logic [SEQ_W_DEF-1:0]   seq;
  } frame_t;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: synchronous write, registered read.
module frame_ram
  import eurorack_pmod_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter type frame_type    = frame_t
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  frame_type       wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output frame_type       rdata
);

  frame_type mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A read hitting the slot being written returns the new frame, so an
  // empty FIFO presents its first frame one cycle after the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/sample_frame_fifo.sv
// Show-ahead frame FIFO for the four calibrated channels, tagged with a
// free-running sequence number, with sticky overflow and a drop counter.
module sample_frame_fifo
  import eurorack_pmod_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SEQ_W = 16
) (
  input  logic                       clk_256fs,
  input  logic                       rst,
  input  logic                       strobe,
  input  logic signed [W-1:0]        cal_in0,
  input  logic signed [W-1:0]        cal_in1,
  input  logic signed [W-1:0]        cal_in2,
  input  logic signed [W-1:0]        cal_in3,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic signed [W-1:0]        frame_ch0,
  output logic signed [W-1:0]        frame_ch1,
  output logic signed [W-1:0]        frame_ch2,
  output logic signed [W-1:0]        frame_ch3,
  output logic [SEQ_W-1:0]           frame_seq,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [15:0]                drop_count,
  input  logic                       clear_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic [N_CH-1:0][W-1:0] ch;
    logic [SEQ_W-1:0]       seq;
  } frame_w_t;

  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_next;
  logic [LW-1:0]    level_next;
  logic [SEQ_W-1:0] seq_ctr;
  logic             pop, wr_en, drop;
  frame_w_t         wr_frame, rd_frame;

  always_comb begin
    pop         = frame_valid && frame_ready;
    wr_en       = strobe && ((level != LW'(DEPTH)) || pop);
    drop        = strobe && !wr_en;
    rd_ptr_next = rd_ptr + AW'(pop);
    level_next  = level;
    if (wr_en && !pop)      level_next = level + LW'(1);
    else if (pop && !wr_en) level_next = level - LW'(1);
  end

  always_comb begin
    wr_frame       = '0;
    wr_frame.ch[0] = cal_in0;
    wr_frame.ch[1] = cal_in1;
    wr_frame.ch[2] = cal_in2;
    wr_frame.ch[3] = cal_in3;
    wr_frame.seq   = seq_ctr;
  end

  // Prefetch the head at the post-pop read pointer so it is already in the
  // RAM's read register the cycle after a pop or a write into an empty FIFO.
  frame_ram #(
    .DEPTH      (DEPTH),
    .AW         (AW),
    .frame_type (frame_w_t)
  ) u_frame_ram (
    .clk   (clk_256fs),
    .rst   (rst),
    .we    (wr_en && !rst),
    .waddr (wr_ptr),
    .wdata (wr_frame),
    .re    (level_next != '0),
    .raddr (rd_ptr_next),
    .rdata (rd_frame)
  );

  always_ff @(posedge clk_256fs) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      frame_valid <= 1'b0;
      seq_ctr     <= '0;
      overflow    <= 1'b0;
      drop_count  <= '0;
    end else begin
      if (wr_en)  wr_ptr  <= wr_ptr + AW'(1);
      if (strobe) seq_ctr <= seq_ctr + SEQ_W'(1);
      rd_ptr      <= rd_ptr_next;
      level       <= level_next;
      frame_valid <= (level_next != '0);
      if (clear_overflow) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 16'd1;
      end
    end
  end

  assign frame_ch0 = rd_frame.ch[0];
  assign frame_ch1 = rd_frame.ch[1];
  assign frame_ch2 = rd_frame.ch[2];
  assign frame_ch3 = rd_frame.ch[3];
  assign frame_seq = rd_frame.seq;

endmodule

// File: tb/tb_sample_frame_fifo.sv
// Directed bench for sample_frame_fifo: reset, single frame, overflow,
// full-with-pop, clear-vs-drop, reset mid-operation and streaming.
module tb_sample_frame_fifo;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned SEQ_W = 16;

  logic                      clk_256fs = 1'b0;
  logic                      rst = 1'b1;
  logic                      strobe = 1'b0;
  logic signed [W-1:0]       cal_in0 = '0, cal_in1 = '0, cal_in2 = '0, cal_in3 = '0;
  logic                      frame_valid;
  logic                      frame_ready = 1'b0;
  logic signed [W-1:0]       frame_ch0, frame_ch1, frame_ch2, frame_ch3;
  logic [SEQ_W-1:0]          frame_seq;
  logic [$clog2(DEPTH):0]    level;
  logic                      overflow;
  logic [15:0]               drop_count;
  logic                      clear_overflow = 1'b0;

  logic [15:0] ch0_u, ch1_u, ch2_u, ch3_u;
  assign ch0_u = frame_ch0;
  assign ch1_u = frame_ch1;
  assign ch2_u = frame_ch2;
  assign ch3_u = frame_ch3;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk_256fs = ~clk_256fs;

  sample_frame_fifo #(
    .W     (W),
    .DEPTH (DEPTH),
    .SEQ_W (SEQ_W)
  ) dut (
    .clk_256fs      (clk_256fs),
    .rst            (rst),
    .strobe         (strobe),
    .cal_in0        (cal_in0),
    .cal_in1        (cal_in1),
    .cal_in2        (cal_in2),
    .cal_in3        (cal_in3),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .frame_ch0      (frame_ch0),
    .frame_ch1      (frame_ch1),
    .frame_ch2      (frame_ch2),
    .frame_ch3      (frame_ch3),
    .frame_seq      (frame_seq),
    .level          (level),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .clear_overflow (clear_overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_256fs);
    #1;
  endtask

  function automatic logic [15:0] pat(input int unsigned k, input int unsigned c);
    return 16'(k * 37 + c * 1000 + 5);
  endfunction

  task automatic push(input int unsigned k);
    cal_in0 = pat(k, 0);
    cal_in1 = pat(k, 1);
    cal_in2 = pat(k, 2);
    cal_in3 = pat(k, 3);
    strobe  = 1'b1;
    tick();
    strobe  = 1'b0;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    strobe         = 1'b0;
    frame_ready    = 1'b0;
    clear_overflow = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain_check(input string tag, input int unsigned first, input int unsigned n);
    frame_ready = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      check_eq({tag, "_valid"}, 32'(frame_valid), 32'd1);
      check_eq({tag, "_seq"}, 32'(frame_seq), 32'(16'(first + i)));
      check_eq({tag, "_ch0"}, 32'(ch0_u), 32'(pat(first + i, 0)));
      tick();
    end
    frame_ready = 1'b0;
    check_eq({tag, "_empty_valid"}, 32'(frame_valid), 32'd0);
    check_eq({tag, "_empty_level"}, 32'(level), 32'd0);
  endtask

  initial begin
    int unsigned exp_seq;
    int unsigned sent;

    // Reset values
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_valid", 32'(frame_valid), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_drop", 32'(drop_count), 32'd0);
    check_eq("rst_seq", 32'(frame_seq), 32'd0);
    check_eq("rst_ch0", 32'(ch0_u), 32'd0);
    check_eq("rst_ch3", 32'(ch3_u), 32'd0);
    rst = 1'b0;
    tick();

    // Single frame, held while the consumer is not ready
    cal_in0 = 16'h1234;
    cal_in1 = 16'hFFFF;
    cal_in2 = 16'h7FFF;
    cal_in3 = 16'h8000;
    strobe  = 1'b1;
    tick();
    strobe  = 1'b0;
    for (int unsigned i = 0; i < 100; i++) begin
      check_eq("single_valid", 32'(frame_valid), 32'd1);
      check_eq("single_ch0", 32'(ch0_u), 32'h1234);
      check_eq("single_ch1", 32'(ch1_u), 32'hFFFF);
      check_eq("single_ch2", 32'(ch2_u), 32'h7FFF);
      check_eq("single_ch3", 32'(ch3_u), 32'h8000);
      check_eq("single_seq", 32'(frame_seq), 32'd0);
      check_eq("single_level", 32'(level), 32'd1);
      tick();
    end
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check_eq("single_pop_valid", 32'(frame_valid), 32'd0);
    check_eq("single_pop_level", 32'(level), 32'd0);

    // Overflow: DEPTH+3 strobes with no consumer
    do_reset();
    for (int unsigned i = 0; i < DEPTH + 3; i++) push(i);
    check_eq("ovf_level", 32'(level), 32'd16);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    check_eq("ovf_drop", 32'(drop_count), 32'd3);
    drain_check("ovf_drain", 0, DEPTH);
    push(DEPTH + 3);
    check_eq("ovf_next_seq", 32'(frame_seq), 32'd19);
    check_eq("ovf_next_ch0", 32'(ch0_u), 32'(pat(19, 0)));
    check_eq("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with strobe and pop in the same cycle
    do_reset();
    for (int unsigned i = 0; i < DEPTH; i++) push(i);
    check_eq("full_level", 32'(level), 32'd16);
    frame_ready = 1'b1;
    push(DEPTH);
    frame_ready = 1'b0;
    check_eq("fullpop_level", 32'(level), 32'd16);
    check_eq("fullpop_drop", 32'(drop_count), 32'd0);
    check_eq("fullpop_ovf", 32'(overflow), 32'd0);
    drain_check("fullpop_drain", 1, DEPTH);

    // Clear coinciding with a drop
    do_reset();
    for (int unsigned i = 0; i < DEPTH + 1; i++) push(i);
    check_eq("clr_pre_drop", 32'(drop_count), 32'd1);
    check_eq("clr_pre_ovf", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    push(DEPTH + 1);
    clear_overflow = 1'b0;
    check_eq("clr_ovf", 32'(overflow), 32'd0);
    check_eq("clr_drop", 32'(drop_count), 32'd0);
    push(DEPTH + 2);
    check_eq("clr_after_drop", 32'(drop_count), 32'd1);
    check_eq("clr_after_ovf", 32'(overflow), 32'd1);
    check_eq("clr_level", 32'(level), 32'd16);

    // Reset with a coincident strobe while holding five frames
    do_reset();
    for (int unsigned i = 0; i < 5; i++) push(i);
    check_eq("rmid_pre_level", 32'(level), 32'd5);
    rst    = 1'b1;
    strobe = 1'b1;
    tick();
    rst    = 1'b0;
    strobe = 1'b0;
    check_eq("rmid_level", 32'(level), 32'd0);
    check_eq("rmid_valid", 32'(frame_valid), 32'd0);
    push(0);
    check_eq("rmid_seq", 32'(frame_seq), 32'd0);
    check_eq("rmid_ch0", 32'(ch0_u), 32'(pat(0, 0)));
    check_eq("rmid_post_level", 32'(level), 32'd1);

    // Streaming with a periodic consumer slower than one pop per cycle
    do_reset();
    exp_seq = 0;
    sent    = 0;
    for (int unsigned cyc = 0; cyc < 600; cyc++) begin
      strobe = ((cyc % 6) == 0) && (sent < 60);
      if (strobe) begin
        cal_in0 = pat(sent, 0);
        cal_in1 = pat(sent, 1);
        cal_in2 = pat(sent, 2);
        cal_in3 = pat(sent, 3);
      end
      frame_ready = ((cyc % 4) == 1);
      if (frame_valid && frame_ready) begin
        check_eq("stream_seq", 32'(frame_seq), 32'(16'(exp_seq)));
        check_eq("stream_ch3", 32'(ch3_u), 32'(pat(exp_seq, 3)));
        exp_seq++;
      end
      if (strobe) sent++;
      tick();
    end
    strobe      = 1'b0;
    frame_ready = 1'b0;
    check_eq("stream_count", exp_seq, 32'd60);
    check_eq("stream_ovf", 32'(overflow), 32'd0);
    check_eq("stream_level", 32'(level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
